// File: rtl/inexrecur_pkg.sv
// Shared constants and entry layout for the inexact-recursion entry buffer.
package inexrecur_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 12;

  // Byte-field placement inside a packed search-state entry
  localparam int unsigned FLD_W     = 8;
  localparam int unsigned FLD_I_LSB = 24;
  localparam int unsigned FLD_Z_LSB = 16;
  localparam int unsigned FLD_K_LSB = 8;
  localparam int unsigned FLD_L_LSB = 0;

  localparam int unsigned MODE_SCAN  = 0;
  localparam int unsigned MODE_STACK = 1;

  typedef struct packed {
    logic [FLD_W-1:0] i;
    logic [FLD_W-1:0] z;
    logic [FLD_W-1:0] k;
    logic [FLD_W-1:0] l;
  } entry_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, old data on collision.
module sdp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write and registered read; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
    if (re) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/inexrecur_entry_buffer.sv
// Entry buffer between the recursion controller and the backtrack stage:
// pushes entries, serves them by scan/stack sequential read or random address.
module inexrecur_entry_buffer
  import inexrecur_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LIFO   = MODE_SCAN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              we,
  input  logic [DATA_W-1:0] w_data,
  input  logic              seq_re,
  input  logic              ran_re,
  input  logic [ADDR_W-1:0] ran_r_addr,
  output logic              r_valid,
  output logic              r_hit,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit          STACK = (LIFO == MODE_STACK);

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  top_ptr_c;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              r_valid_q, r_valid_d;
  logic              r_hit_q, r_hit_d;
  logic              zero_q, zero_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              full_c, empty_c;
  logic              pop_c;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign full_c    = (wr_ptr_q == CNT_W'(DEPTH));
  assign empty_c   = (wr_ptr_q == '0);
  assign top_ptr_c = wr_ptr_q - CNT_W'(1);

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .w_addr (ram_waddr),
    .w_data (w_data),
    .re     (ram_re),
    .r_addr (ram_raddr),
    .r_data (ram_rdata)
  );

  // Next-state: flush, read selection (random over sequential), then push
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    r_valid_d   = 1'b0;
    r_hit_d     = 1'b0;
    zero_d      = zero_q;
    r_addr_d    = r_addr_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_waddr   = wr_ptr_q[ADDR_W-1:0];
    ram_raddr   = '0;
    pop_c       = 1'b0;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      zero_d      = 1'b1;
      r_addr_d    = '0;
    end else begin
      if (ran_re) begin
        r_valid_d = 1'b1;
        r_addr_d  = ran_r_addr;
        if ({1'b0, ran_r_addr} < wr_ptr_q) begin
          ram_re    = 1'b1;
          ram_raddr = ran_r_addr;
          r_hit_d   = 1'b1;
          zero_d    = 1'b0;
        end else begin
          zero_d    = 1'b1;
        end
      end else if (seq_re) begin
        r_valid_d = 1'b1;
        if (STACK) begin
          if (!empty_c) begin
            pop_c     = 1'b1;
            ram_re    = 1'b1;
            ram_raddr = top_ptr_c[ADDR_W-1:0];
            r_addr_d  = top_ptr_c[ADDR_W-1:0];
            r_hit_d   = 1'b1;
            zero_d    = 1'b0;
          end else begin
            r_addr_d    = '0;
            zero_d      = 1'b1;
            underflow_d = 1'b1;
          end
        end else begin
          if (rd_ptr_q < wr_ptr_q) begin
            ram_re    = 1'b1;
            ram_raddr = rd_ptr_q[ADDR_W-1:0];
            r_addr_d  = rd_ptr_q[ADDR_W-1:0];
            rd_ptr_d  = rd_ptr_q + CNT_W'(1);
            r_hit_d   = 1'b1;
            zero_d    = 1'b0;
          end else begin
            r_addr_d    = rd_ptr_q[ADDR_W-1:0];
            zero_d      = 1'b1;
            underflow_d = 1'b1;
          end
        end
      end

      // A push alongside a pop replaces the popped slot; count is unchanged
      if (we) begin
        if (pop_c) begin
          ram_we    = 1'b1;
          ram_waddr = top_ptr_c[ADDR_W-1:0];
        end else if (!full_c) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end else if (pop_c) begin
        wr_ptr_d = top_ptr_c;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      r_valid_q   <= 1'b0;
      r_hit_q     <= 1'b0;
      zero_q      <= 1'b1;
      r_addr_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      r_valid_q   <= r_valid_d;
      r_hit_q     <= r_hit_d;
      zero_q      <= zero_d;
      r_addr_q    <= r_addr_d;
    end
  end

  // Miss and reset force zero data; otherwise the RAM read register holds the last hit
  assign r_data    = zero_q ? '0 : ram_rdata;
  assign r_valid   = r_valid_q;
  assign r_hit     = r_hit_q;
  assign r_addr    = r_addr_q;
  assign count     = wr_ptr_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_inexrecur_entry_buffer.sv
// Directed bench: scan (ADDR_W=12), stack (ADDR_W=4) and small stack (ADDR_W=2) instances share stimulus.
module tb_inexrecur_entry_buffer;

  logic        clk = 1'b0;
  logic        rst_n, clear, we, seq_re, ran_re;
  logic [31:0] w_data;
  logic [11:0] ran_r_addr;

  logic        s_valid, s_hit, s_full, s_empty, s_ovf, s_unf;
  logic [11:0] s_addr;
  logic [31:0] s_data;
  logic [12:0] s_count;

  logic        k_valid, k_hit, k_full, k_empty, k_ovf, k_unf;
  logic [3:0]  k_addr;
  logic [31:0] k_data;
  logic [4:0]  k_count;

  logic        m_valid, m_hit, m_full, m_empty, m_ovf, m_unf;
  logic [1:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inexrecur_entry_buffer #(.DATA_W(32), .ADDR_W(12), .LIFO(0)) u_scan (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we), .w_data(w_data),
    .seq_re(seq_re), .ran_re(ran_re), .ran_r_addr(ran_r_addr),
    .r_valid(s_valid), .r_hit(s_hit), .r_addr(s_addr), .r_data(s_data),
    .count(s_count), .full(s_full), .empty(s_empty),
    .overflow(s_ovf), .underflow(s_unf));

  inexrecur_entry_buffer #(.DATA_W(32), .ADDR_W(4), .LIFO(1)) u_stack (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we), .w_data(w_data),
    .seq_re(seq_re), .ran_re(ran_re), .ran_r_addr(ran_r_addr[3:0]),
    .r_valid(k_valid), .r_hit(k_hit), .r_addr(k_addr), .r_data(k_data),
    .count(k_count), .full(k_full), .empty(k_empty),
    .overflow(k_ovf), .underflow(k_unf));

  inexrecur_entry_buffer #(.DATA_W(32), .ADDR_W(2), .LIFO(1)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we), .w_data(w_data),
    .seq_re(seq_re), .ran_re(ran_re), .ran_r_addr(ran_r_addr[1:0]),
    .r_valid(m_valid), .r_hit(m_hit), .r_addr(m_addr), .r_data(m_data),
    .count(m_count), .full(m_full), .empty(m_empty),
    .overflow(m_ovf), .underflow(m_unf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; we = 1'b0; seq_re = 1'b0; ran_re = 1'b0;
    w_data = '0; ran_r_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] d);
    we = 1'b1; w_data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({s_valid, s_hit, s_addr, s_data, s_count, s_full, s_empty, s_ovf, s_unf} !==
        {1'b0, 1'b0, 12'd0, 32'd0, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_scan got v%b h%b a%0d d%h c%0d f%b e%b o%b u%b", s_valid, s_hit,
               s_addr, s_data, s_count, s_full, s_empty, s_ovf, s_unf);
    end
    n_tests++;
    if ({k_valid, k_hit, k_count, k_full, k_empty, k_ovf, k_unf, k_data} !==
        {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_stack got c%0d e%b f%b d%h exp c0 e1 f0 d0", k_count, k_empty, k_full, k_data);
    end
    n_tests++;
    if ({m_count, m_full, m_empty, m_ovf, m_unf} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_small got c%0d f%b e%b exp c0 f0 e1", m_count, m_full, m_empty);
    end
  endtask

  task automatic test_scan_push_read();
    logic [31:0] v [3] = '{32'h02010006, 32'h01000006, 32'h02000606};
    for (int i = 0; i < 3; i++) begin
      push(v[i]);
      seq_re = 1'b1;
      tick();
      seq_re = 1'b0;
      n_tests++;
      if ({s_valid, s_hit, s_addr, s_data} !== {1'b1, 1'b1, 12'(i), v[i]}) begin
        n_fail++;
        $display("FAIL scan_read%0d got v%b h%b a%0d d%h exp v1 h1 a%0d d%h",
                 i, s_valid, s_hit, s_addr, s_data, i, v[i]);
      end
    end
    n_tests++;
    if ({s_count, s_empty, s_full} !== {13'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL scan_count got c%0d e%b f%b exp c3 e0 f0", s_count, s_empty, s_full);
    end
  endtask

  task automatic test_random_read();
    logic [11:0] a [4] = '{12'd2, 12'd1, 12'd0, 12'd4};
    logic [31:0] d [4] = '{32'h02000606, 32'h01000006, 32'h02010006, 32'h0};
    logic        h [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ran_re = 1'b1; ran_r_addr = a[i];
      tick();
      ran_re = 1'b0;
      n_tests++;
      if ({s_valid, s_hit, s_addr, s_data} !== {1'b1, h[i], a[i], d[i]}) begin
        n_fail++;
        $display("FAIL rand_read%0d got v%b h%b a%0d d%h exp v1 h%b a%0d d%h",
                 i, s_valid, s_hit, s_addr, s_data, h[i], a[i], d[i]);
      end
    end
    ran_re = 1'b1; ran_r_addr = 12'd1;
    tick();
    ran_re = 1'b0;
    tick();
    n_tests++;
    if ({s_valid, s_data, s_unf} !== {1'b0, 32'h01000006, 1'b0}) begin
      n_fail++;
      $display("FAIL rand_hold got v%b d%h u%b exp v0 d01000006 u0", s_valid, s_data, s_unf);
    end
  endtask

  task automatic test_scan_underflow_clear();
    seq_re = 1'b1;
    tick();
    seq_re = 1'b0;
    n_tests++;
    if ({s_valid, s_hit, s_data, s_unf} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL scan_underflow got v%b h%b d%h u%b exp v1 h0 d0 u1", s_valid, s_hit, s_data, s_unf);
    end
    tick();
    tick();
    n_tests++;
    if (s_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_sticky got %b exp 1", s_unf);
    end
    clear = 1'b1; we = 1'b1; w_data = 32'hDEADBEEF; seq_re = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({s_count, s_empty, s_unf, s_valid, s_data} !== {13'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL scan_clear got c%0d e%b u%b v%b d%h exp c0 e1 u0 v0 d0",
               s_count, s_empty, s_unf, s_valid, s_data);
    end
    we = 1'b1; w_data = 32'h0A0B0C0D; seq_re = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({s_valid, s_hit, s_unf, s_count} !== {1'b1, 1'b0, 1'b1, 13'd1}) begin
      n_fail++;
      $display("FAIL scan_push_read_same got v%b h%b u%b c%0d exp v1 h0 u1 c1", s_valid, s_hit, s_unf, s_count);
    end
    seq_re = 1'b1;
    tick();
    seq_re = 1'b0;
    n_tests++;
    if ({s_valid, s_hit, s_addr, s_data} !== {1'b1, 1'b1, 12'd0, 32'h0A0B0C0D}) begin
      n_fail++;
      $display("FAIL scan_read_after_same got h%b a%0d d%h exp h1 a0 d0a0b0c0d", s_hit, s_addr, s_data);
    end
  endtask

  task automatic test_stack();
    logic [31:0] v [3] = '{32'h02010006, 32'h01000006, 32'h02000606};
    do_reset();
    for (int i = 0; i < 3; i++) push(v[i]);
    for (int i = 2; i >= 0; i--) begin
      seq_re = 1'b1;
      tick();
      seq_re = 1'b0;
      n_tests++;
      if ({k_valid, k_hit, k_addr, k_data} !== {1'b1, 1'b1, 4'(i), v[i]}) begin
        n_fail++;
        $display("FAIL stack_pop%0d got h%b a%0d d%h exp h1 a%0d d%h", i, k_hit, k_addr, k_data, i, v[i]);
      end
    end
    n_tests++;
    if ({k_empty, k_count, k_unf} !== {1'b1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL stack_empty got e%b c%0d u%b exp e1 c0 u0", k_empty, k_count, k_unf);
    end
    seq_re = 1'b1;
    tick();
    seq_re = 1'b0;
    n_tests++;
    if ({k_valid, k_hit, k_data, k_unf} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL stack_underflow got v%b h%b d%h u%b exp v1 h0 d0 u1", k_valid, k_hit, k_data, k_unf);
    end
    we = 1'b1; w_data = 32'h11223344; seq_re = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({k_hit, k_count} !== {1'b0, 5'd1}) begin
      n_fail++;
      $display("FAIL stack_push_pop_empty got h%b c%0d exp h0 c1", k_hit, k_count);
    end
    seq_re = 1'b1;
    tick();
    seq_re = 1'b0;
    n_tests++;
    if ({k_hit, k_addr, k_data, k_count} !== {1'b1, 4'd0, 32'h11223344, 5'd0}) begin
      n_fail++;
      $display("FAIL stack_pop_pushed got h%b a%0d d%h c%0d exp h1 a0 d11223344 c0", k_hit, k_addr, k_data, k_count);
    end
  endtask

  task automatic test_small_full();
    logic [31:0] v [5] = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h54};
    logic [31:0] w [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_reset();
    for (int i = 0; i < 3; i++) push(v[i]);
    n_tests++;
    if ({m_full, m_count} !== {1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL small_three got f%b c%0d exp f0 c3", m_full, m_count);
    end
    push(v[3]);
    n_tests++;
    if ({m_full, m_count, m_ovf, m_empty} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL small_full got f%b c%0d o%b e%b exp f1 c4 o0 e0", m_full, m_count, m_ovf, m_empty);
    end
    push(v[4]);
    n_tests++;
    if ({m_full, m_count, m_ovf} !== {1'b1, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL small_overflow got f%b c%0d o%b exp f1 c4 o1", m_full, m_count, m_ovf);
    end
    ran_re = 1'b1; ran_r_addr = 12'd3;
    tick();
    ran_re = 1'b0;
    n_tests++;
    if ({m_hit, m_addr, m_data} !== {1'b1, 2'd3, 32'h43}) begin
      n_fail++;
      $display("FAIL small_mem3 got h%b a%0d d%h exp h1 a3 d43", m_hit, m_addr, m_data);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) push(w[i]);
    we = 1'b1; w_data = 32'hBEEF; seq_re = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({m_valid, m_hit, m_addr, m_data, m_count, m_ovf, m_full} !==
        {1'b1, 1'b1, 2'd3, 32'hA3, 3'd4, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL small_push_pop_full got h%b a%0d d%h c%0d o%b f%b exp h1 a3 da3 c4 o0 f1",
               m_hit, m_addr, m_data, m_count, m_ovf, m_full);
    end
    ran_re = 1'b1; ran_r_addr = 12'd3;
    tick();
    ran_re = 1'b0;
    n_tests++;
    if ({m_hit, m_data} !== {1'b1, 32'hBEEF}) begin
      n_fail++;
      $display("FAIL small_replaced_top got h%b d%h exp h1 dbeef", m_hit, m_data);
    end
  endtask

  task automatic test_priority_async_reset();
    do_reset();
    push(32'hAAAA0001);
    push(32'hBBBB0002);
    ran_re = 1'b1; ran_r_addr = 12'd1; seq_re = 1'b1;
    tick();
    idle_inputs();
    n_tests++;
    if ({s_valid, s_hit, s_addr, s_data, s_unf} !== {1'b1, 1'b1, 12'd1, 32'hBBBB0002, 1'b0}) begin
      n_fail++;
      $display("FAIL ran_over_seq got h%b a%0d d%h u%b exp h1 a1 dbbbb0002 u0", s_hit, s_addr, s_data, s_unf);
    end
    seq_re = 1'b1;
    tick();
    seq_re = 1'b0;
    n_tests++;
    if ({s_hit, s_addr, s_data} !== {1'b1, 12'd0, 32'hAAAA0001}) begin
      n_fail++;
      $display("FAIL rd_ptr_unchanged got h%b a%0d d%h exp h1 a0 daaaa0001", s_hit, s_addr, s_data);
    end
    seq_re = 1'b1;
    tick();
    seq_re = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({s_valid, s_hit, s_addr, s_data, s_count, s_empty} !==
        {1'b0, 1'b0, 12'd0, 32'd0, 13'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset got v%b h%b a%0d d%h c%0d e%b exp v0 h0 a0 d0 c0 e1",
               s_valid, s_hit, s_addr, s_data, s_count, s_empty);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_scan_push_read();
    test_random_read();
    test_scan_underflow_clear();
    test_stack();
    test_small_full();
    test_priority_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
